// File: rtl/uart_pkg.sv
// Shared constants, register map and state types for the memory-mapped 8N1 UART.
package uart_pkg;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_IRQ_EN = 2'd3;

  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_EMPTY   = 1;
  localparam int unsigned ST_RX_EMPTY   = 2;
  localparam int unsigned ST_RX_OVERRUN = 3;
  localparam int unsigned ST_FRAME_ERR  = 4;

  localparam logic [DIV_W-1:0] DIV_MIN = 16'd4;

  localparam logic [31:0] RX_EMPTY_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Field order matches the STATUS bit indices above (tx_full is bit 0).
  typedef struct packed {
    logic frame_err;
    logic rx_overrun;
    logic rx_empty;
    logic tx_empty;
    logic tx_full;
  } status_t;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/uart_periph_if.sv
// CPU-side valid/ready bus shared with RAM and SPI ROM on the picorv32 memory map.
interface uart_periph_if;

  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output valid, wstrb, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, wstrb, addr, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so pointers wrap for free.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  // Push into a full FIFO and pop from an empty one are silently ignored.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: bus decode, control/status registers, TX/RX FIFOs and serial FSMs.
module uart_periph
  import uart_pkg::*;
#(
  parameter int unsigned DIV_RESET  = 139,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  uart_periph_if.slave  bus,
  output logic          tx,
  input  logic          rx,
  output logic          irq
);

  logic [DIV_W-1:0]  div;
  logic [1:0]        irq_en;
  logic              rx_overrun;
  logic              frame_err;
  status_t           status_c;

  logic              req_c;
  logic              rd_c;
  logic              wr_c;
  logic [1:0]        reg_sel_c;
  logic              sts_wr_c;
  logic              ovr_set_c;
  logic              unused_c;

  logic              tx_push_c;
  logic              tx_pop_c;
  logic [DATA_W-1:0] tx_dout;
  logic              tx_full;
  logic              tx_empty;

  logic              rx_pop_c;
  logic              rx_push_q;
  logic              rx_frame_q;
  logic [DATA_W-1:0] rx_dout;
  logic              rx_full;
  logic              rx_empty;

  tx_state_t         tx_state;
  logic [DIV_W-1:0]  tx_cnt;
  logic [DIV_W-1:0]  tx_div;
  logic [DATA_W-1:0] tx_shift;
  logic [2:0]        tx_bit;

  rx_state_t         rx_state;
  logic [DIV_W-1:0]  rx_cnt;
  logic [DIV_W-1:0]  rx_div;
  logic [DATA_W-1:0] rx_shift;
  logic [2:0]        rx_bit;
  logic              rx_s1;
  logic              rx_s2;
  logic              rx_prev;

  // A request is accepted on the edge that raises ready, so side effects happen exactly once.
  assign req_c     = bus.valid && !bus.ready;
  assign rd_c      = req_c && (bus.wstrb == 4'h0);
  assign wr_c      = req_c && (bus.wstrb != 4'h0);
  assign reg_sel_c = bus.addr[3:2];
  assign sts_wr_c  = wr_c && (reg_sel_c == REG_STATUS) && bus.wstrb[0];
  assign tx_push_c = wr_c && (reg_sel_c == REG_DATA) && bus.wstrb[0];
  assign rx_pop_c  = rd_c && (reg_sel_c == REG_DATA) && !rx_empty;
  assign ovr_set_c = rx_push_q && rx_full;
  assign unused_c  = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:16], bus.wstrb[3:2]};

  assign status_c.frame_err  = frame_err;
  assign status_c.rx_overrun = rx_overrun;
  assign status_c.rx_empty   = rx_empty;
  assign status_c.tx_empty   = tx_empty;
  assign status_c.tx_full    = tx_full;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push_c),
    .din   (bus.wdata[7:0]),
    .pop   (tx_pop_c),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push_q),
    .din   (rx_shift),
    .pop   (rx_pop_c),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Bus response, control registers, sticky flags and interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ready  <= 1'b0;
      bus.rdata  <= '0;
      div        <= DIV_W'(DIV_RESET);
      irq_en     <= '0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      irq        <= 1'b0;
    end else begin
      bus.ready <= req_c;
      bus.rdata <= '0;
      irq       <= (irq_en[0] && !rx_empty) || (irq_en[1] && tx_empty);
      if (rd_c) begin
        case (reg_sel_c)
          REG_DATA:   bus.rdata <= rx_empty ? RX_EMPTY_WORD : {24'h0, rx_dout};
          REG_STATUS: bus.rdata <= {27'h0, status_c};
          REG_DIV:    bus.rdata <= {16'h0, div};
          REG_IRQ_EN: bus.rdata <= {30'h0, irq_en};
          default:    bus.rdata <= '0;
        endcase
      end
      if (wr_c && (reg_sel_c == REG_DIV) && (bus.wstrb[1:0] != 2'b00)) begin
        div <= clamp_div(bus.wdata[15:0]);
      end
      if (wr_c && (reg_sel_c == REG_IRQ_EN) && bus.wstrb[0]) begin
        irq_en <= bus.wdata[1:0];
      end
      // A new event wins over a clear landing in the same cycle.
      rx_overrun <= ovr_set_c || (rx_overrun && !(sts_wr_c && bus.wdata[ST_RX_OVERRUN]));
      frame_err  <= rx_frame_q || (frame_err && !(sts_wr_c && bus.wdata[ST_FRAME_ERR]));
    end
  end

  // TX pops in IDLE, or at the end of STOP to run frames back to back.
  assign tx_pop_c = !tx_empty &&
                    ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_cnt == '0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= DIV_W'(DIV_RESET);
      tx_shift <= '0;
      tx_bit   <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx <= 1'b1;
          if (tx_pop_c) begin
            tx_shift <= tx_dout;
            tx_div   <= div;
            tx_cnt   <= div - DIV_W'(1);
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          tx <= 1'b0;
          if (tx_cnt == '0) begin
            tx_cnt   <= tx_div - DIV_W'(1);
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - DIV_W'(1);
          end
        end
        TX_DATA: begin
          tx <= tx_shift[0];
          if (tx_cnt == '0) begin
            tx_cnt   <= tx_div - DIV_W'(1);
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
            end
          end else begin
            tx_cnt <= tx_cnt - DIV_W'(1);
          end
        end
        TX_STOP: begin
          tx <= 1'b1;
          if (tx_cnt == '0) begin
            if (tx_pop_c) begin
              tx_shift <= tx_dout;
              tx_div   <= div;
              tx_cnt   <= div - DIV_W'(1);
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - DIV_W'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // rx is asynchronous; only rx_s2 and later are used by logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX samples each bit at its centre: half a bit after the falling edge, then every DIV clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_div     <= DIV_W'(DIV_RESET);
      rx_shift   <= '0;
      rx_bit     <= '0;
      rx_push_q  <= 1'b0;
      rx_frame_q <= 1'b0;
    end else begin
      rx_push_q  <= 1'b0;
      rx_frame_q <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2 && rx_prev) begin
            rx_div   <= div;
            rx_cnt   <= (div >> 1) - DIV_W'(1);
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_cnt   <= rx_div - DIV_W'(1);
              rx_bit   <= '0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - DIV_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            rx_cnt   <= rx_div - DIV_W'(1);
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end
          end else begin
            rx_cnt <= rx_cnt - DIV_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              rx_push_q <= 1'b1;
            end else begin
              rx_frame_q <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - DIV_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// Directed bench for uart_periph: register vectors plus serial TX/RX frame sequences.
module tb_uart_periph;

  localparam logic [31:0] A_DATA   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_DIV    = 32'h8;
  localparam logic [31:0] A_IRQ_EN = 32'hC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic tx;
  logic irq;

  int checks = 0;
  int failures = 0;
  int mon_div = 139;
  logic [9:0] mon_q[$];

  uart_periph_if bus ();

  uart_periph #(.DIV_RESET(139), .FIFO_DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .rx    (rx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  function automatic vec_t mk(input bit we, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] e, input logic ei);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.wstrb = s; v.exp_rd = e; v.exp_irq = ei;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    bus.valid = 1'b1; bus.addr = a; bus.wdata = d; bus.wstrb = s;
    do begin
      @(posedge clk); #1; n++;
    end while (bus.ready !== 1'b1 && n < 20);
    if (bus.ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL bus_timeout addr=0x%08h", a);
    end
    rd = bus.rdata;
    @(negedge clk);
    bus.valid = 1'b0; bus.wstrb = 4'h0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    bus_xfer(a, d, s, dummy);
  endtask

  task automatic rd_check(input logic [31:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] rd;
    bus_xfer(a, 32'h0, 4'h0, rd);
    check(nm, 64'(rd), 64'(exp));
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx = fr[i];
      repeat (d - 1) @(negedge clk);
    end
    @(negedge clk); rx = 1'b1;
  endtask

  // Push one byte and compare tx clock by clock against the ideal 8N1 waveform.
  task automatic tx_wave(input logic [7:0] b, input int d, input string nm);
    logic [63:0] cap;
    logic [63:0] expv;
    logic [9:0]  fr;
    fr = {1'b1, b, 1'b0};
    cap = '0; expv = '0;
    for (int k = 0; k < 44; k++) begin
      if (k / d < 10) expv[k] = fr[k / d];
      else expv[k] = 1'b1;
    end
    mon_div = d;
    bus_write(A_DATA, {24'h0, b}, 4'h1);
    @(posedge clk); #1;
    check({nm, "_latency"}, 64'(tx), 64'(1));
    for (int k = 0; k < 44; k++) begin
      @(posedge clk); #1;
      cap[k] = tx;
    end
    check({nm, "_wave"}, cap, expv);
  endtask

  // Free-running decoder of whatever the DUT sends on tx: {stop, data, start}.
  initial begin : tx_mon
    logic [9:0] f;
    int d;
    forever begin
      @(negedge tx);
      d = mon_div;
      repeat (d / 2) @(posedge clk);
      #1 f[0] = tx;
      for (int i = 1; i < 10; i++) begin
        repeat (d) @(posedge clk);
        #1 f[i] = tx;
      end
      mon_q.push_back(f);
    end
  end

  initial begin : main
    vec_t vecs[12];
    logic [31:0] rd;
    int n;

    bus.valid = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;

    repeat (4) @(posedge clk);
    #1;
    check("rst_tx", 64'(tx), 64'(1));
    check("rst_irq", 64'(irq), 64'(0));
    check("rst_ready", 64'(bus.ready), 64'(0));
    check("rst_rdata", 64'(bus.rdata), 64'(0));
    @(negedge clk); reset = 1'b0;

    vecs[0]  = mk(0, A_STATUS,     32'h0,  4'h0, 32'h6,         1'b0);
    vecs[1]  = mk(0, A_DATA,       32'h0,  4'h0, 32'h8000_0000, 1'b0);
    vecs[2]  = mk(1, A_IRQ_EN,     32'h2,  4'h1, 32'h0,         1'b1);
    vecs[3]  = mk(0, A_STATUS,     32'h0,  4'h0, 32'h6,         1'b1);
    vecs[4]  = mk(1, A_IRQ_EN,     32'h1,  4'h1, 32'h0,         1'b0);
    vecs[5]  = mk(1, A_IRQ_EN,     32'h3,  4'h1, 32'h0,         1'b1);
    vecs[6]  = mk(1, A_IRQ_EN,     32'h0,  4'h1, 32'h0,         1'b0);
    vecs[7]  = mk(1, A_STATUS,     32'h18, 4'h1, 32'h0,         1'b0);
    vecs[8]  = mk(0, 32'hFFFF_FFF4, 32'h0, 4'h0, 32'h6,         1'b0);
    vecs[9]  = mk(1, A_DATA,       32'hFF, 4'hE, 32'h0,         1'b0);
    vecs[10] = mk(0, A_STATUS,     32'h0,  4'h0, 32'h6,         1'b0);
    vecs[11] = mk(0, 32'h20,       32'h0,  4'h0, 32'h8000_0000, 1'b0);

    for (int i = 0; i < 12; i++) begin
      bus_xfer(vecs[i].addr, vecs[i].wdata, vecs[i].we ? vecs[i].wstrb : 4'h0, rd);
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("vec%0d_irq", i), 64'(irq), 64'(vecs[i].exp_irq));
    end
    check("idle_ready", 64'(bus.ready), 64'(0));
    check("idle_rdata", 64'(bus.rdata), 64'(0));

    // TX waveform at DIV=4, then DIV=1 which must be clamped to 4.
    bus_write(A_DIV, 32'h4, 4'h3);
    tx_wave(8'h55, 4, "tx55");
    rd_check(A_STATUS, 32'h6, "tx55_status");
    bus_write(A_DIV, 32'h1, 4'h1);
    tx_wave(8'hF0, 4, "txclamp");

    // Fill TX while the first frame is on the wire: 16 buffered, last write dropped.
    repeat (20) @(posedge clk);
    bus_write(A_DIV, 32'd20, 4'h3);
    mon_div = 20;
    mon_q.delete();
    bus_write(A_DATA, 32'h00, 4'h1);
    repeat (3) @(posedge clk);
    for (int i = 1; i <= 17; i++) bus_write(A_DATA, 32'(i), 4'h1);
    rd_check(A_STATUS, 32'h5, "fill_full");
    n = 0;
    while (mon_q.size() < 1 && n < 400) begin @(posedge clk); n++; end
    repeat (15) @(posedge clk);
    rd_check(A_STATUS, 32'h4, "fill_not_full");
    n = 0;
    while (mon_q.size() < 17 && n < 5000) begin @(posedge clk); n++; end
    check("fill_frames", 64'(mon_q.size()), 64'(17));
    for (int i = 0; i < 17 && i < mon_q.size(); i++)
      check($sformatf("fill_byte%0d", i), 64'(mon_q[i]), 64'({1'b1, 8'(i), 1'b0}));
    repeat (600) @(posedge clk);
    check("fill_dropped", 64'(mon_q.size()), 64'(17));
    rd_check(A_STATUS, 32'h6, "fill_drained");

    // RX single byte with rx_not_empty interrupt.
    bus_write(A_DIV, 32'd8, 4'h1);
    bus_write(A_IRQ_EN, 32'h1, 4'h1);
    repeat (2) @(posedge clk);
    #1 check("rx_irq_low", 64'(irq), 64'(0));
    send_rx(8'hA3, 1'b1, 8);
    n = 0;
    while (irq !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check("rx_irq_rise", 64'(irq), 64'(1));
    rd_check(A_DATA, 32'h0000_00A3, "rx_byte");
    rd_check(A_DATA, 32'h8000_0000, "rx_empty_read");
    repeat (2) @(posedge clk);
    #1 check("rx_irq_fall", 64'(irq), 64'(0));
    bus_write(A_IRQ_EN, 32'h0, 4'h1);

    // 17 frames unread: overrun, first 16 intact.
    for (int i = 0; i < 17; i++) send_rx(8'(8'h30 + i), 1'b1, 8);
    repeat (10) @(posedge clk);
    rd_check(A_STATUS, 32'h0A, "ovr_status");
    bus_write(A_STATUS, 32'h8, 4'h1);
    rd_check(A_STATUS, 32'h02, "ovr_cleared");
    for (int i = 0; i < 16; i++)
      rd_check(A_DATA, 32'(8'h30 + i), $sformatf("ovr_byte%0d", i));
    rd_check(A_DATA, 32'h8000_0000, "ovr_drained");

    // Stop bit low: frame error, no byte; clearing bit 3 must not touch it.
    send_rx(8'h5A, 1'b0, 8);
    repeat (10) @(posedge clk);
    rd_check(A_STATUS, 32'h16, "ferr_status");
    bus_write(A_STATUS, 32'h8, 4'h1);
    rd_check(A_STATUS, 32'h16, "ferr_sticky");
    bus_write(A_STATUS, 32'h10, 4'h1);
    rd_check(A_STATUS, 32'h06, "ferr_cleared");

    // Glitch shorter than DIV/2 is rejected as a false start.
    @(negedge clk); rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(posedge clk);
    rd_check(A_STATUS, 32'h06, "glitch_status");
    rd_check(A_DATA, 32'h8000_0000, "glitch_nodata");

    // Reset in the middle of a TX frame and a partial RX frame.
    mon_div = 8;
    bus_write(A_DATA, 32'h00, 4'h1);
    @(negedge clk); rx = 1'b0;
    repeat (20) @(negedge clk);
    #1 check("pre_reset_tx", 64'(tx), 64'(0));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("reset_tx", 64'(tx), 64'(1));
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    rd_check(A_STATUS, 32'h06, "post_reset_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_periph.md
# uart_periph

Memory-mapped 8N1 UART slave for the picorv32 SoC. It sits downstream of the CPU memory-map decoder and attaches to the same valid/ready/wstrb/addr/wdata/rdata bus as the RAM and SPI ROM. It buffers transmit and receive bytes in FIFOs, drives a level interrupt into one `irq` bit, and connects to two board pins.

## Interface
- `DIV_RESET`, 139: reset value of the baud divider, in clocks per bit (16 MHz / 115200).
- `FIFO_DEPTH`, 16: entries per FIFO; must be a power of two, at least 2.
- `clk` in 1: system clock (`clk_16MHz`); single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `valid` in 1: access request, already qualified by the decoder's address select.
- `ready` out 1: one-cycle completion pulse.
- `wstrb` in 4: byte write strobes; 0 means read.
- `addr` in 32: only `addr[3:2]` is decoded.
- `wdata` in 32: write data.
- `rdata` out 32: read data; valid only while `ready` is high, 0 otherwise.
- `tx` out 1: serial output; idle high.
- `rx` in 1: serial input; asynchronous to `clk`.
- `irq` out 1: level interrupt request.

## Operation
- Register map (`addr[3:2]`):
  - 0 DATA
    - Write with `wstrb[0]` pushes `wdata[7:0]` into the TX FIFO.
    - Read pops the RX FIFO and returns `{1'b0, 23'b0, byte}`.
    - Read while RX is empty returns 0x8000_0000 and does not pop.
  - 1 STATUS
    - Bits: [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_overrun (sticky), [4] frame_err (sticky).
    - Writing 1 to bit 3 or bit 4 clears that bit. Other bits are read-only.
  - 2 DIV
    - `wdata[15:0]`, written when `wstrb[1:0]` are nonzero. Values below 4 are stored as 4.
  - 3 IRQ_EN
    - Bit 0 enables rx_not_empty; bit 1 enables tx_empty.
- `irq = (IRQ_EN[0] & !rx_empty) | (IRQ_EN[1] & tx_empty)`, registered.
- Write to DATA while TX is full: byte dropped, `ready` still given, no error flag.
- TX FSM states IDLE → START → DATA → STOP → IDLE.
  - IDLE pops the FIFO when it is non-empty and latches DIV.
  - Each state lasts DIV clocks. DATA shifts 8 bits, LSB first.
  - STOP returns to IDLE, or goes straight to START if the FIFO is non-empty (back-to-back frames).
- RX path: 2-flop synchronizer, then FSM IDLE → START → DATA → STOP.
  - IDLE waits for a falling edge, latches DIV and waits DIV/2 (floor).
  - START: if the sample is high, the start is false and the FSM returns to IDLE. Otherwise it samples every DIV clocks, 8 data bits.
  - STOP, stop bit = 1: push the byte. If the FIFO is full, drop it and set rx_overrun.
  - STOP, stop bit = 0: drop the byte and set frame_err.
- A DIV write mid-frame takes effect at the next frame start on each side.
- Simultaneous RX push and CPU pop in the same cycle: both happen, and the count is unchanged.

## Timing
- Reset values:
  - Outputs: `ready=0`, `rdata=0`, `tx=1`, `irq=0`.
  - Internal: FIFOs empty, DIV=`DIV_RESET`, IRQ_EN=0, sticky flags 0, both FSMs IDLE.
- Reset mid-frame: `tx` returns high on the first edge of reset and the partial RX byte is discarded.
- Bus handshake:
  - `ready` pulses exactly once, in the cycle after the first cycle `valid` is seen.
  - It is never asserted on two consecutive cycles.
  - `valid` is held until `ready`.
  - Side effects (push, pop, register write, flag clear) occur once, on the `ready` edge.
- TX latency: push on edge N, pop on edge N+1, `tx` falls after edge N+2. A frame lasts 10×DIV clocks.
- RX latency: byte visible (rx_empty=0) 2 clocks after the mid-stop-bit sample. Add 2 clocks of synchronizer delay to the start detect.
- `irq` follows its inputs with 1 cycle of delay.

## Structure
- Package `uart_pkg`:
  - Register offset constants.
  - STATUS bit indices.
  - `tx_state_t` / `rx_state_t` enums.
  - `DIV_MIN = 4`.
- Sub-module `sync_fifo #(WIDTH=8, DEPTH)`, instantiated twice.
  - Ports: push/pop/data, with full/empty outputs.
  - Uses a `$clog2(DEPTH)+1`-bit count. Pointers wrap modulo DEPTH.
- Top level holds the bus decode, registers, and both FSMs.

## Test plan
- Reset, then read STATUS → 0x0000_0006. `tx`=1, `irq`=0.
- DIV=4, write 0x55 to DATA → `tx` shows 0,1,0,1,0,1,0,1,0,1, each bit lasting exactly 4 clocks. tx_empty reads 1 afterwards.
- Write 17 bytes with TX stalled (DIV=0xFFFF, first byte popped) → 16 buffered and the 17th dropped. tx_full=1 until the first frame ends.
- Drive `rx` with 0xA3 at DIV=8, IRQ_EN=1 → `irq` rises. DATA reads 0x0000_00A3, then 0x8000_0000, then `irq` falls.
- Receive 17 frames without reading → rx_overrun=1 and the first 16 bytes are intact. Writing 0x8 to STATUS clears the flag.
- Frame with stop bit 0 → frame_err=1 and rx_empty remains 1. A glitch low shorter than DIV/2 → no byte and no flag.
